// File: rtl/pkt_classifier_pkg.sv
// Shared constants and types for the packet classifier: header field
// positions inside beat 0, match constants, FSM state and class encodings.
package pkt_classifier_pkg;

    // Header values in wire byte order as they appear on tdata
    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0008;
    localparam logic [7:0]  IPPROT_UDP    = 8'h11;

    // Bit offsets of the classified fields inside beat 0
    localparam int ETH_TYPE_LSB  = 128;   // tdata[143:128]
    localparam int IP_PROTO_LSB  = 216;   // tdata[223:216]
    localparam int UDP_DPORT_LSB = 320;   // tdata[335:320]

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FWD_DATA = 2'd1,
        ST_FWD_CTL  = 2'd2,
        ST_DROP     = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CLS_DATA = 2'd0,
        CLS_CTL  = 2'd1,
        CLS_DROP = 2'd2
    } pkt_class_t;

endpackage

// File: rtl/pkt_classifier_v2_axis_skid_buf.sv
// Two-entry AXI-Stream skid buffer: a registered output stage plus one
// spill register. Ready is registered (free while the spill slot is empty),
// which keeps full throughput and breaks the tready path toward upstream.
module axis_skid_buf #(
    parameter int DW = 512,
    parameter int TW = 128
) (
    input  logic            clk,
    input  logic            aresetn,
    input  logic [DW-1:0]   s_tdata,
    input  logic [DW/8-1:0] s_tkeep,
    input  logic [TW-1:0]   s_tuser,
    input  logic            s_tlast,
    input  logic            s_tvalid,
    output logic            s_tready,
    output logic [DW-1:0]   m_tdata,
    output logic [DW/8-1:0] m_tkeep,
    output logic [TW-1:0]   m_tuser,
    output logic            m_tlast,
    output logic            m_tvalid,
    input  logic            m_tready
);

    localparam int PW = DW + DW/8 + TW + 1;

    logic [PW-1:0] in_word;
    logic [PW-1:0] out_word;
    logic [PW-1:0] skid_word;
    logic          out_valid;
    logic          skid_valid;
    logic          push;

    assign in_word  = {s_tdata, s_tkeep, s_tuser, s_tlast};
    assign push     = s_tvalid && s_tready;
    assign s_tready = !skid_valid;

    assign {m_tdata, m_tkeep, m_tuser, m_tlast} = out_word;
    assign m_tvalid = out_valid;

    // Refill the output stage from the spill slot first, otherwise straight
    // from the input; park the input in the spill slot when the output stalls
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            out_word   <= '0;
            out_valid  <= 1'b0;
            skid_word  <= '0;
            skid_valid <= 1'b0;
        end else if (!out_valid || m_tready) begin
            if (skid_valid) begin
                out_word   <= skid_word;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= push;
                if (push) begin
                    out_word <= in_word;
                end
            end
        end else if (push) begin
            skid_word  <= in_word;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/pkt_classifier_v2.sv
// Packet classifier: classifies each AXI-Stream packet on beat 0 as DATA,
// CTL or DROP and steers all its beats to the data path, the control path,
// or nowhere. Optional packet counters are built when the macro
// PKT_CLASSIFIER_STATS_EN is defined; otherwise the stat outputs are zero.
module pkt_classifier_v2
    import pkt_classifier_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = 512,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_CTL_PORTS        = 4,
    parameter int FWD_NON_UDP          = 0
) (
    input  logic                              clk,
    input  logic                              aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
    output logic                              c_m_axis_tvalid,
    output logic                              c_m_axis_tlast,
    input  logic                              c_m_axis_tready,
    input  logic [16*NUM_CTL_PORTS-1:0]       ctl_port_list,
    input  logic [NUM_CTL_PORTS-1:0]          ctl_port_en,
    output logic [31:0]                       stat_data_pkts,
    output logic [31:0]                       stat_ctl_pkts,
    output logic [31:0]                       stat_drop_pkts
);

    logic [15:0] eth_type;
    logic [7:0]  ip_proto;
    logic [15:0] dst_port;
    logic        is_udp;
    logic        port_hit;
    pkt_class_t  beat_class;

    state_t      state;
    state_t      state_next;
    logic        in_ready;
    logic        push_data;
    logic        push_ctl;
    logic        data_ready;
    logic        ctl_ready;
    logic        first_accept;

    assign eth_type = s_axis_tdata[ETH_TYPE_LSB +: 16];
    assign ip_proto = s_axis_tdata[IP_PROTO_LSB +: 8];
    assign dst_port = s_axis_tdata[UDP_DPORT_LSB +: 16];

    // Classify the current input beat; only meaningful when it is beat 0
    always_comb begin
        port_hit = 1'b0;
        for (int i = 0; i < NUM_CTL_PORTS; i++) begin
            if (ctl_port_en[i] && (ctl_port_list[16*i +: 16] == dst_port)) begin
                port_hit = 1'b1;
            end
        end
        is_udp = (eth_type == ETH_TYPE_IPV4) && (ip_proto == IPPROT_UDP);
        if (is_udp && port_hit) begin
            beat_class = CLS_CTL;
        end else if (is_udp || (FWD_NON_UDP != 0)) begin
            beat_class = CLS_DATA;
        end else begin
            beat_class = CLS_DROP;
        end
    end

    // State register; the packet class lives in the state once beat 0 is taken
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, input ready and steering of the accepted beat
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        push_data  = 1'b0;
        push_ctl   = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = data_ready && ctl_ready;
                if (s_axis_tvalid && in_ready) begin
                    push_data = (beat_class == CLS_DATA);
                    push_ctl  = (beat_class == CLS_CTL);
                    if (!s_axis_tlast) begin
                        case (beat_class)
                            CLS_DATA: state_next = ST_FWD_DATA;
                            CLS_CTL:  state_next = ST_FWD_CTL;
                            default:  state_next = ST_DROP;
                        endcase
                    end
                end
            end
            ST_FWD_DATA: begin
                in_ready  = data_ready;
                push_data = s_axis_tvalid && in_ready;
                if (push_data && s_axis_tlast) begin
                    state_next = ST_IDLE;
                end
            end
            ST_FWD_CTL: begin
                in_ready = ctl_ready;
                push_ctl = s_axis_tvalid && in_ready;
                if (push_ctl && s_axis_tlast) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                in_ready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_next = ST_IDLE;
                end
            end
        endcase
    end

    // Upstream sees no ready while reset is held
    assign s_axis_tready = in_ready && aresetn;
    assign first_accept  = (state == ST_IDLE) && s_axis_tvalid && s_axis_tready;

    axis_skid_buf #(
        .DW(C_S_AXIS_DATA_WIDTH),
        .TW(C_S_AXIS_TUSER_WIDTH)
    ) data_skid (
        .clk      (clk),
        .aresetn  (aresetn),
        .s_tdata  (s_axis_tdata),
        .s_tkeep  (s_axis_tkeep),
        .s_tuser  (s_axis_tuser),
        .s_tlast  (s_axis_tlast),
        .s_tvalid (push_data),
        .s_tready (data_ready),
        .m_tdata  (m_axis_tdata),
        .m_tkeep  (m_axis_tkeep),
        .m_tuser  (m_axis_tuser),
        .m_tlast  (m_axis_tlast),
        .m_tvalid (m_axis_tvalid),
        .m_tready (m_axis_tready)
    );

    axis_skid_buf #(
        .DW(C_S_AXIS_DATA_WIDTH),
        .TW(C_S_AXIS_TUSER_WIDTH)
    ) ctl_skid (
        .clk      (clk),
        .aresetn  (aresetn),
        .s_tdata  (s_axis_tdata),
        .s_tkeep  (s_axis_tkeep),
        .s_tuser  (s_axis_tuser),
        .s_tlast  (s_axis_tlast),
        .s_tvalid (push_ctl),
        .s_tready (ctl_ready),
        .m_tdata  (c_m_axis_tdata),
        .m_tkeep  (c_m_axis_tkeep),
        .m_tuser  (c_m_axis_tuser),
        .m_tlast  (c_m_axis_tlast),
        .m_tvalid (c_m_axis_tvalid),
        .m_tready (c_m_axis_tready)
    );

`ifdef PKT_CLASSIFIER_STATS_EN
    logic [31:0] data_cnt;
    logic [31:0] ctl_cnt;
    logic [31:0] drop_cnt;

    // Count each packet once, by class, when its first beat is accepted
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            data_cnt <= 32'd0;
            ctl_cnt  <= 32'd0;
            drop_cnt <= 32'd0;
        end else if (first_accept) begin
            case (beat_class)
                CLS_DATA: data_cnt <= data_cnt + 32'd1;
                CLS_CTL:  ctl_cnt  <= ctl_cnt + 32'd1;
                default:  drop_cnt <= drop_cnt + 32'd1;
            endcase
        end
    end

    assign stat_data_pkts = data_cnt;
    assign stat_ctl_pkts  = ctl_cnt;
    assign stat_drop_pkts = drop_cnt;
`else
    logic unused_first_accept;
    assign unused_first_accept = first_accept;
    assign stat_data_pkts = 32'd0;
    assign stat_ctl_pkts  = 32'd0;
    assign stat_drop_pkts = 32'd0;
`endif

endmodule
